ahfp_norm_round: RTL



---
 rtl/ahfp_pkg.sv | 22 ++
 rtl/ahfp_lzd48.sv | 20 ++
 rtl/ahfp_norm_round.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ahfp_pkg.sv
// Shared constants and field types for the single-precision normalize/round path.
package ahfp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 48;
  localparam int FRAC_W   = 23;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Status flags; at most one is set for any result.
  typedef struct packed {
    logic ovf;
    logic uf;
    logic zero;
  } flags_t;

endpackage

// File: rtl/ahfp_lzd48.sv
// 48-bit leading-one detector: bit index of the most significant set bit, plus any-bit-set.
module ahfp_lzd48
  import ahfp_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  output logic [5:0]        pos,
  output logic              valid
);

  // Ascending scan so the highest set bit wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < MANT_W; i++) begin
      if (mant[i]) pos = 6'(i);
    end
  end

  assign valid = |mant;

endmodule

// File: rtl/ahfp_norm_round.sv
// Two-stage normalize, round-to-nearest-even and pack to binary32 with status flags.
// Stage 1 holds the operand and its leading-zero count; stage 2 shifts, rounds and packs.
module ahfp_norm_round
  import ahfp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [9:0]        in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_ovf,
  output logic              out_uf,
  output logic              out_zero
);

  // Handshake: a stage transfers on an edge where its valid and ready are both high;
  // a stage is ready when empty or when the stage after it is ready, so a full pipe
  // shifts in lockstep with no bubble, and a stalled stage holds its contents.
  logic s1_v, s2_v;
  logic s1_rdy, s2_rdy;

  assign s2_rdy    = !s2_v || out_ready;
  assign s1_rdy    = !s1_v || s2_rdy;
  assign in_ready  = s1_rdy;
  assign out_valid = s2_v;

  // ---------------- stage 1 ----------------
  logic [5:0] lzd_pos;
  logic       lzd_valid;
  logic [5:0] lz_in;

  ahfp_lzd48 u_lzd (
    .mant  (in_mant),
    .pos   (lzd_pos),
    .valid (lzd_valid)
  );

  assign lz_in = 6'd47 - lzd_pos;

  logic              s1_sign;
  logic [9:0]        s1_exp;
  logic [MANT_W-1:0] s1_mant;
  logic [5:0]        s1_lz;
  logic              s1_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_mant <= '0;
      s1_lz   <= '0;
      s1_nz   <= 1'b0;
    end else if (s1_rdy) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= in_exp;
        s1_mant <= in_mant;
        s1_lz   <= lz_in;
        s1_nz   <= lzd_valid;
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [MANT_W-1:0] sh;
  logic signed [10:0] e_adj, e_fin;
  logic              rnd;
  logic [24:0]       sig_inc;
  logic [23:0]       sig_fin;
  fp32_t             pack_data;
  flags_t            pack_flags;

  always_comb begin
    sh    = s1_mant << s1_lz;
    // in_exp refers to bit 46, so a leading one at bit 47 (lz = 0) adds one.
    e_adj = $signed({s1_exp[9], s1_exp}) + 11'sd1 - $signed({5'b0, s1_lz});
    rnd   = sh[23] & ((|sh[22:0]) | sh[24]);
    sig_inc = {1'b0, sh[47:24]} + {24'b0, rnd};
    if (sig_inc[24]) begin
      sig_fin = 24'h800000;
      e_fin   = e_adj + 11'sd1;
    end else begin
      sig_fin = sig_inc[23:0];
      e_fin   = e_adj;
    end

    pack_data  = '0;
    pack_flags = '0;
    pack_data.sign = s1_sign;
    if (!s1_nz) begin
      pack_flags.zero = 1'b1;
    end else if (e_fin >= 11'(EXP_MAX)) begin
      pack_data.exp  = 8'hFF;
      pack_flags.ovf = 1'b1;
    end else if (e_fin <= 11'sd0) begin
      pack_flags.uf = 1'b1;
    end else begin
      pack_data.exp  = e_fin[7:0];
      pack_data.frac = sig_fin[FRAC_W-1:0];
    end
  end

  fp32_t  s2_data;
  flags_t s2_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v     <= 1'b0;
      s2_data  <= '0;
      s2_flags <= '0;
    end else if (s2_rdy) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data  <= pack_data;
        s2_flags <= pack_flags;
      end
    end
  end

  assign out_data = s2_data;
  assign out_ovf  = s2_flags.ovf;
  assign out_uf   = s2_flags.uf;
  assign out_zero = s2_flags.zero;

endmodule
